bot_feeder: RTL and testbench

Upstream issue stage for the full pipeline: accepts a batch of bots from the host-side stream over a valid/ready handshake and drives them into the pipeline's bot, index, valid and permutation inputs, one per cycle at most. Assigns sequential bot indices per batch and throttles issue against the pipeline's lagging FIFO fullness using an in-flight issue window. After the last bot it drains and signals batch completion so result readout can start.

---
 rtl/bot_feeder_pkg.sv | 42 ++++
 rtl/bot_feeder_issue_window.sv | 42 ++++
 rtl/bot_feeder.sv | 198 +++++++++++++++++++
 tb/tb_bot_feeder.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bot_feeder_pkg.sv
// Shared types and constants for the bot_feeder issue stage.
package bot_feeder_pkg;

    // Payload widths of the host stream and pipeline inputs.
    localparam int unsigned BOT_W   = 128;
    localparam int unsigned PERM_W  = 6;
    localparam int unsigned FULL_W  = 5;
    localparam int unsigned STATS_W = 32;

    // Estimate is fifoFullness plus the in-flight window count, no saturation.
    localparam int unsigned EST_W = 6;

    // Longest supported lag and the number of registered window stages it implies.
    localparam int unsigned MAX_LAG        = 8;
    localparam int unsigned WIN_STAGES_MAX = MAX_LAG - 1;
    localparam int unsigned WIN_CNT_W      = 4;

    // FSM encoding.
    localparam int unsigned STATE_W = 2;
    typedef enum logic [STATE_W-1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } feeder_state_e;

    localparam logic [STATE_W-1:0] ST_IDLE  = S_IDLE;
    localparam logic [STATE_W-1:0] ST_RUN   = S_RUN;
    localparam logic [STATE_W-1:0] ST_DRAIN = S_DRAIN;
    localparam logic [STATE_W-1:0] ST_DONE  = S_DONE;

    // Population count over the window stages.
    function automatic logic [WIN_CNT_W-1:0] win_popcount(input logic [WIN_STAGES_MAX-1:0] v);
        logic [WIN_CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < int'(WIN_STAGES_MAX); i++) begin
            c = c + WIN_CNT_W'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/bot_feeder_issue_window.sv
// In-flight issue window: remembers recent issues not yet visible on fifoFullness.
// An issue accepted in cycle N reaches fifoFullness in cycle N+LAG_CYCLES, so it
// must be counted during N+1 .. N+LAG_CYCLES-1, i.e. LAG_CYCLES-1 registered
// stages of the LAG_CYCLES-long window (the issue cycle itself is the first slot,
// and cannot be counted without making inReady depend on inValid).
// LAG_CYCLES must be in 1..8.
module issue_window
    import bot_feeder_pkg::*;
#(
    parameter int unsigned LAG_CYCLES = 4
)
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    output logic [WIN_CNT_W-1:0] count
);

    localparam int unsigned STAGES = LAG_CYCLES - 1;
    localparam logic [WIN_STAGES_MAX-1:0] STAGE_MASK =
        WIN_STAGES_MAX'((8'd1 << STAGES) - 8'd1);

    logic [WIN_STAGES_MAX-1:0] win_q;
    logic [WIN_STAGES_MAX-1:0] win_d;

    // Shift a new issue in every cycle; stages beyond the lag are masked off.
    always_comb begin
        win_d = {win_q[WIN_STAGES_MAX-2:0], push};
    end

    // Window state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win_q <= '0;
        end else begin
            win_q <= win_d;
        end
    end

    assign count = win_popcount(win_q & STAGE_MASK);

endmodule

// File: rtl/bot_feeder.sv
// bot_feeder: issues a host batch of bots into the pipeline, one per cycle at
// most, with sequential indices, throttled by lagged FIFO fullness plus an
// in-flight window, then drains and pulses batchDone.
// Optional build macro FEEDER_STATS_EN adds the saturating stallCount counter;
// without it stallCount is tied to zero.
module bot_feeder
    import bot_feeder_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 9,
    parameter int unsigned FULLNESS_LIMIT = 16,
    parameter int unsigned LAG_CYCLES     = 4,
    parameter int unsigned DRAIN_CYCLES   = 64
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  batchStart,
    input  logic                  inValid,
    output logic                  inReady,
    input  logic [BOT_W-1:0]      inBot,
    input  logic [PERM_W-1:0]     inValidPermutations,
    input  logic                  inLast,
    output logic [BOT_W-1:0]      bot,
    output logic [ADDR_WIDTH-1:0] botIndex,
    output logic                  isBotValid,
    output logic [PERM_W-1:0]     validBotPermutations,
    input  logic [FULL_W-1:0]     fifoFullness,
    output logic                  batchDone,
    output logic                  busy,
    output logic                  indexOverflow,
    output logic [STATS_W-1:0]    stallCount
);

    localparam int unsigned DRAIN_W = $clog2(DRAIN_CYCLES + 1);

    logic [STATE_W-1:0]    state_q,     state_d;
    logic [ADDR_WIDTH-1:0] idx_q,       idx_d;
    logic                  exhausted_q, exhausted_d;
    logic [DRAIN_W-1:0]    settle_q,    settle_d;
    logic [BOT_W-1:0]      bot_q,       bot_d;
    logic [ADDR_WIDTH-1:0] bot_index_q, bot_index_d;
    logic                  valid_q,     valid_d;
    logic [PERM_W-1:0]     perm_q,      perm_d;
    logic                  done_q,      done_d;
    logic                  busy_q,      busy_d;
    logic                  ovf_q,       ovf_d;

    logic [WIN_CNT_W-1:0]  win_count;
    logic [EST_W-1:0]      estimate;
    logic                  in_ready_c;
    logic                  accept;
    logic                  win_push;
    logic                  start;

    // Only issues with a live permutation occupy pipeline FIFO space.
    assign win_push = accept & (|inValidPermutations);

    issue_window #(
        .LAG_CYCLES (LAG_CYCLES)
    ) u_window (
        .clk   (clk),
        .rst   (rst),
        .push  (win_push),
        .count (win_count)
    );

    // Ready depends only on registered state and fifoFullness, never on inValid.
    assign estimate   = EST_W'(fifoFullness) + EST_W'(win_count);
    assign in_ready_c = (state_q == ST_RUN) && (estimate < EST_W'(FULLNESS_LIMIT)) && !exhausted_q;
    assign accept     = inValid & in_ready_c;
    assign start      = batchStart && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        exhausted_d = exhausted_q;
        settle_d    = settle_q;
        bot_d       = bot_q;
        bot_index_d = bot_index_q;
        perm_d      = perm_q;
        valid_d     = 1'b0;
        done_d      = 1'b0;
        ovf_d       = ovf_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d     = ST_RUN;
                    idx_d       = '0;
                    exhausted_d = 1'b0;
                    ovf_d       = 1'b0;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    bot_d       = inBot;
                    perm_d      = inValidPermutations;
                    bot_index_d = idx_q;
                    valid_d     = 1'b1;
                    idx_d       = idx_q + ADDR_WIDTH'(1);
                    if (idx_q == '1) begin
                        exhausted_d = 1'b1;
                    end
                    if (inLast) begin
                        state_d  = ST_DRAIN;
                        settle_d = DRAIN_W'(DRAIN_CYCLES);
                    end
                end
                // Index space used up: the offered bot is refused and flagged.
                if (inValid && !in_ready_c && exhausted_q) begin
                    ovf_d = 1'b1;
                end
            end
            ST_DRAIN: begin
                if ((fifoFullness != '0) || (win_count != '0)) begin
                    settle_d = DRAIN_W'(DRAIN_CYCLES);
                end else if (settle_q == '0) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    settle_d = settle_q - DRAIN_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            exhausted_q <= 1'b0;
            settle_q    <= DRAIN_W'(DRAIN_CYCLES);
            bot_q       <= '0;
            bot_index_q <= '0;
            valid_q     <= 1'b0;
            perm_q      <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            exhausted_q <= exhausted_d;
            settle_q    <= settle_d;
            bot_q       <= bot_d;
            bot_index_q <= bot_index_d;
            valid_q     <= valid_d;
            perm_q      <= perm_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            ovf_q       <= ovf_d;
        end
    end

`ifdef FEEDER_STATS_EN
    logic [STATS_W-1:0] stall_q, stall_d;

    // Count RUN cycles where upstream offers a bot that is refused; saturating.
    always_comb begin
        stall_d = stall_q;
        if (start) begin
            stall_d = '0;
        end else if ((state_q == ST_RUN) && inValid && !in_ready_c && (stall_q != '1)) begin
            stall_d = stall_q + STATS_W'(1);
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stallCount = stall_q;
`else
    assign stallCount = '0;
`endif

    assign inReady              = in_ready_c;
    assign bot                  = bot_q;
    assign botIndex             = bot_index_q;
    assign isBotValid           = valid_q;
    assign validBotPermutations = perm_q;
    assign batchDone            = done_q;
    assign busy                 = busy_q;
    assign indexOverflow        = ovf_q;

endmodule

// File: tb/tb_bot_feeder.sv
// Directed scoreboard bench for bot_feeder.
module tb_bot_feeder;

    localparam int unsigned AW    = 9;
    localparam int unsigned DRAIN = 64;
    localparam int unsigned LAG   = 4;
`ifdef FEEDER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          batchStart;
    logic          inValid;
    logic          inReady;
    logic [127:0]  inBot;
    logic [5:0]    inValidPermutations;
    logic          inLast;
    logic [127:0]  bot;
    logic [AW-1:0] botIndex;
    logic          isBotValid;
    logic [5:0]    validBotPermutations;
    logic [4:0]    fifoFullness;
    logic          batchDone;
    logic          busy;
    logic          indexOverflow;
    logic [31:0]   stallCount;

    bot_feeder #(
        .ADDR_WIDTH     (AW),
        .FULLNESS_LIMIT (16),
        .LAG_CYCLES     (LAG),
        .DRAIN_CYCLES   (DRAIN)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .batchStart           (batchStart),
        .inValid              (inValid),
        .inReady              (inReady),
        .inBot                (inBot),
        .inValidPermutations  (inValidPermutations),
        .inLast               (inLast),
        .bot                  (bot),
        .botIndex             (botIndex),
        .isBotValid           (isBotValid),
        .validBotPermutations (validBotPermutations),
        .fifoFullness         (fifoFullness),
        .batchDone            (batchDone),
        .busy                 (busy),
        .indexOverflow        (indexOverflow),
        .stallCount           (stallCount)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic [127:0]  b;
        logic [AW-1:0] idx;
        logic [5:0]    m;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   last_issue_cyc = 0;
    int   done_cyc = 0;
    int   done_count = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Pop the scoreboard for every issue seen and record batchDone pulses.
    task automatic monitor();
        exp_t e;
        if (isBotValid === 1'b1) begin
            n_chk++;
            assert (sb.size() != 0) else begin
                n_fail++;
                $error("FAIL unexpected_issue observed idx=%0d expected=no issue", botIndex);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("issue_index", 128'(botIndex), 128'(e.idx));
                chk("issue_bot", bot, e.b);
                chk("issue_perm", 128'(validBotPermutations), 128'(e.m));
            end
            last_issue_cyc = cyc;
        end
        if (batchDone === 1'b1) begin
            done_count++;
            done_cyc = cyc;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        monitor();
    endtask

    task automatic idle();
        inValid = 1'b0;
        inLast  = 1'b0;
    endtask

    task automatic start_batch();
        batchStart = 1'b1;
        tick();
        batchStart = 1'b0;
        chk("start_busy", 128'(busy), 128'(1'b1));
    endtask

    // Offer one bot; exp_acc is whether this cycle must accept it.
    task automatic send(input logic [127:0] b, input logic [5:0] m, input logic last,
                        input logic exp_acc, input logic [AW-1:0] exp_idx);
        exp_t e;
        inValid             = 1'b1;
        inBot               = b;
        inValidPermutations = m;
        inLast              = last;
        #1;
        chk("in_ready", 128'(inReady), 128'(exp_acc));
        if (exp_acc) begin
            e.b   = b;
            e.idx = exp_idx;
            e.m   = m;
            sb.push_back(e);
        end
        tick();
        chk("issue_latency", 128'(isBotValid), 128'(exp_acc));
    endtask

    task automatic wait_done(input int limit);
        int start_cnt;
        start_cnt = done_count;
        for (int i = 0; i < limit; i++) begin
            if (done_count != start_cnt) break;
            tick();
        end
        chk("batch_done_seen", 128'(done_count), 128'(start_cnt + 1));
    endtask

    task automatic check_reset();
        chk("rst_bot", bot, 128'd0);
        chk("rst_index", 128'(botIndex), 128'd0);
        chk("rst_valid", 128'(isBotValid), 128'd0);
        chk("rst_perm", 128'(validBotPermutations), 128'd0);
        chk("rst_ready", 128'(inReady), 128'd0);
        chk("rst_done", 128'(batchDone), 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_ovf", 128'(indexOverflow), 128'd0);
        chk("rst_stall", 128'(stallCount), 128'd0);
    endtask

    initial begin
        int n_acc;
        rst                 = 1'b1;
        batchStart          = 1'b0;
        inValid             = 1'b0;
        inBot               = '0;
        inValidPermutations = '0;
        inLast              = 1'b0;
        fifoFullness        = '0;

        // Reset values, then idle.
        #1 rst = 1'b0;
        #2;
        check_reset();
        @(negedge clk);
        rst = 1'b1;
        tick();
        tick();
        chk("idle_ready", 128'(inReady), 128'd0);
        chk("idle_busy", 128'(busy), 128'd0);

        // Three bots, then drain; a batchStart during DRAIN is ignored.
        start_batch();
        send(rnd128(), 6'h3F, 1'b0, 1'b1, AW'(0));
        send(rnd128(), 6'h00, 1'b0, 1'b1, AW'(1));
        send(rnd128(), 6'h01, 1'b1, 1'b1, AW'(2));
        idle();
        #1;
        chk("drain_ready", 128'(inReady), 128'd0);
        chk("drain_busy", 128'(busy), 128'd1);
        for (int i = 0; i < 200; i++) begin
            if (done_count != 0) break;
            if (i == 10) batchStart = 1'b1;
            tick();
            batchStart = 1'b0;
        end
        chk("drain_done_seen", 128'(done_count), 128'd1);
        // Last issue's window bit stays live LAG-1 cycles, then DRAIN+1 settle cycles.
        chk("drain_done_gap", 128'(done_cyc - last_issue_cyc), 128'(DRAIN + LAG));
        chk("done_busy", 128'(busy), 128'd0);
        repeat (80) tick();
        chk("done_once", 128'(done_count), 128'd1);
        chk("sb_empty_1", 128'(sb.size()), 128'd0);

        // Throttle: fullness 14, two issues fill the window to the limit.
        fifoFullness = 5'd14;
        start_batch();
        n_acc = 0;
        for (int k = 0; k < 12; k++) begin
            send(rnd128(), 6'(k % 63 + 1), 1'b0, (k % 4) < 2, AW'(n_acc));
            if ((k % 4) < 2) n_acc++;
        end
        fifoFullness = 5'd0;
        send(rnd128(), 6'h01, 1'b1, 1'b1, AW'(n_acc));
        idle();
        wait_done(200);
        chk("stall_after_throttle", 128'(stallCount), STATS ? 128'd6 : 128'd0);

        // Stall counting at the limit, then reset mid-batch with 10 bots issued.
        start_batch();
        chk("stall_cleared", 128'(stallCount), 128'd0);
        fifoFullness = 5'd16;
        for (int k = 0; k < 7; k++) begin
            send(rnd128(), 6'h01, 1'b0, 1'b0, AW'(0));
        end
        idle();
        chk("stall_seven", 128'(stallCount), STATS ? 128'd7 : 128'd0);
        fifoFullness = 5'd0;
        for (int k = 0; k < 10; k++) begin
            send(rnd128(), 6'(k + 1), 1'b0, 1'b1, AW'(k));
        end
        idle();
        #2 rst = 1'b0;
        #1;
        check_reset();
        @(negedge clk);
        rst = 1'b1;
        start_batch();
        for (int k = 0; k < 3; k++) begin
            send(rnd128(), 6'h07, 1'b0, 1'b1, AW'(k));
        end
        idle();
        tick();
        chk("sb_empty_2", 128'(sb.size()), 128'd0);

        // Index exhaustion: 512 issues, the 513th bot is refused.
        #2 rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        start_batch();
        for (int i = 0; i <= 512; i++) begin
            if (i == 512) chk("ovf_before", 128'(indexOverflow), 128'd0);
            send(rnd128(), 6'(i % 63 + 1), 1'b0, i < 512, AW'(i));
        end
        idle();
        chk("ovf_set", 128'(indexOverflow), 128'd1);
        chk("exhausted_ready", 128'(inReady), 128'd0);
        chk("exhausted_busy", 128'(busy), 128'd1);
        tick();
        chk("ovf_sticky", 128'(indexOverflow), 128'd1);
        chk("sb_empty_3", 128'(sb.size()), 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
